// File: rtl/adder_pkg.sv
// Shared definitions for the sequential adder: FSM state encoding and a
// constant ceil-log2 helper used to size the chunk counter.
// No ports; imported by seq_adder.
package adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // ceil(log2(v)); returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder: {co, s} = a + b + ci.
// Ports: a, b (CHUNK bits), ci (1) in; s (CHUNK bits), co (1) out.
// No state; purely combinational.
module chunk_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign s     = total[CHUNK-1:0];
  assign co    = total[CHUNK];

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle adder: sum/carry = x + y + cin, CHUNK bits per clock, LSB first.
// Ports: clk, rst (sync, active-high), start, x, y, cin in; busy, done, sum, carry out.
// Handshake: start accepted in IDLE or DONE, busy for N=WIDTH/CHUNK cycles, then a 1-cycle done.
module seq_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_adder: CHUNK must be in [1, WIDTH] and divide WIDTH");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_nxt;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;
  logic             accept;
  logic             last;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == CW'(N - 1));

  // The low chunk of each operand shift register is always the chunk being added.
  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a (a_sh[CHUNK-1:0]),
    .b (b_sh[CHUNK-1:0]),
    .ci(c_reg),
    .s (chunk_s),
    .co(chunk_co)
  );

  // Partial sum fills from the top and shifts down, so after N steps
  // chunk 0 has arrived at bit 0.
  always_comb begin
    psum_nxt                  = psum >> CHUNK;
    psum_nxt[WIDTH-1 -: CHUNK] = chunk_s;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      a_sh  <= x;
      b_sh  <= y;
      c_reg <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> CHUNK;
      b_sh  <= b_sh >> CHUNK;
      c_reg <= chunk_co;
      psum  <= psum_nxt;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum   <= psum_nxt;
        carry <= chunk_co;
      end
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Testbench for seq_adder: directed WIDTH=8 cases plus a WIDTH=16 sweep over all CHUNK sizes.
module tb_seq_adder;

  logic clk;
  logic rst;

  // WIDTH=8, CHUNK=1
  logic       a_start, a_cin, a_busy, a_done, a_carry;
  logic [7:0] a_x, a_y, a_sum;
  // WIDTH=8, CHUNK=4
  logic       b_start, b_cin, b_busy, b_done, b_carry;
  logic [7:0] b_x, b_y, b_sum;
  // WIDTH=16, CHUNK = 1,2,4,8,16 sharing one stimulus
  logic        w_start, w_cin;
  logic [15:0] w_x, w_y;
  logic        w_busy  [5];
  logic        w_done  [5];
  logic        w_carry [5];
  logic [15:0] w_sum   [5];

  int checks = 0;
  int errors = 0;

  // per-run observation stats for the 8-bit DUTs
  int         busy_cnt, done_cnt, first_done, second_done, overlap, unstable;
  logic [7:0] first_sum, done_sum;
  logic       first_carry, done_carry;

  seq_adder #(.WIDTH(8), .CHUNK(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .x(a_x), .y(a_y), .cin(a_cin),
    .busy(a_busy), .done(a_done), .sum(a_sum), .carry(a_carry)
  );

  seq_adder #(.WIDTH(8), .CHUNK(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .x(b_x), .y(b_y), .cin(b_cin),
    .busy(b_busy), .done(b_done), .sum(b_sum), .carry(b_carry)
  );

  for (genvar g = 0; g < 5; g++) begin : g_w
    seq_adder #(.WIDTH(16), .CHUNK(1 << g)) u_w (
      .clk(clk), .rst(rst), .start(w_start), .x(w_x), .y(w_y), .cin(w_cin),
      .busy(w_busy[g]), .done(w_done[g]), .sum(w_sum[g]), .carry(w_carry[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    busy_cnt = 0; done_cnt = 0; first_done = -1; second_done = -1;
    overlap = 0; unstable = 0;
    first_sum = '0; first_carry = 1'b0; done_sum = '0; done_carry = 1'b0;
  endtask

  task automatic sample(input int c, input logic bz, input logic dn,
                        input logic [7:0] s, input logic cy);
    if (bz) busy_cnt++;
    if (bz && dn) overlap++;
    if (dn) begin
      done_cnt++;
      if (first_done < 0) begin
        first_done = c; first_sum = s; first_carry = cy;
      end else begin
        second_done = c;
      end
      done_sum = s; done_carry = cy;
    end
  endtask

  initial begin
    int lat [5];
    int dcnt [5];
    logic [16:0] res [5];
    logic [16:0] expv;

    rst = 1'b1;
    a_start = 0; a_x = '0; a_y = '0; a_cin = 0;
    b_start = 0; b_x = '0; b_y = '0; b_cin = 0;
    w_start = 0; w_x = '0; w_y = '0; w_cin = 0;
    tick();
    tick();
    chk("reset_busy",  a_busy,  1'b0);
    chk("reset_done",  a_done,  1'b0);
    chk("reset_sum",   a_sum,   8'h00);
    chk("reset_carry", a_carry, 1'b0);
    chk("reset_b_sum", b_sum,   8'h00);
    rst = 1'b0;
    tick();

    // FF + 01, CHUNK=1: wraps to 00 with carry out
    clear_stats();
    a_x = 8'hFF; a_y = 8'h01; a_cin = 0; a_start = 1;
    tick();
    a_start = 0;
    for (int c = 0; c < 12; c++) begin
      sample(c, a_busy, a_done, a_sum, a_carry);
      tick();
    end
    chk("t1_busy_cycles", busy_cnt,   8);
    chk("t1_done_count",  done_cnt,   1);
    chk("t1_latency",     first_done, 8);
    chk("t1_sum",         done_sum,   8'h00);
    chk("t1_carry",       done_carry, 1'b1);
    chk("t1_overlap",     overlap,    0);
    chk("t1_sum_hold",    a_sum,      8'h00);
    chk("t1_carry_hold",  a_carry,    1'b1);

    // CHUNK=4: 3C + 5A = 96
    clear_stats();
    b_x = 8'h3C; b_y = 8'h5A; b_cin = 0; b_start = 1;
    tick();
    b_start = 0;
    for (int c = 0; c < 5; c++) begin
      sample(c, b_busy, b_done, b_sum, b_carry);
      tick();
    end
    chk("t2a_latency", first_done, 2);
    chk("t2a_busy",    busy_cnt,   2);
    chk("t2a_sum",     done_sum,   8'h96);
    chk("t2a_carry",   done_carry, 1'b0);

    // CHUNK=4: 00 + 00 + cin = 01
    clear_stats();
    b_x = 8'h00; b_y = 8'h00; b_cin = 1; b_start = 1;
    tick();
    b_start = 0;
    for (int c = 0; c < 5; c++) begin
      sample(c, b_busy, b_done, b_sum, b_carry);
      tick();
    end
    chk("t2b_latency", first_done, 2);
    chk("t2b_sum",     done_sum,   8'h01);
    chk("t2b_carry",   done_carry, 1'b0);

    // start during RUN is ignored
    clear_stats();
    a_x = 8'h10; a_y = 8'h20; a_cin = 0; a_start = 1;
    tick();
    a_start = 0;
    for (int c = 0; c < 13; c++) begin
      sample(c, a_busy, a_done, a_sum, a_carry);
      if (c == 2) begin
        a_start = 1; a_x = 8'hFF; a_y = 8'hFF;
      end else begin
        a_start = 0;
      end
      tick();
    end
    chk("t3_done_count", done_cnt,   1);
    chk("t3_latency",    first_done, 8);
    chk("t3_busy",       busy_cnt,   8);
    chk("t3_sum",        done_sum,   8'h30);
    chk("t3_carry",      done_carry, 1'b0);

    // reset mid-operation abandons the add
    a_x = 8'hFF; a_y = 8'h01; a_cin = 1; a_start = 1;
    tick();
    a_start = 0;
    tick();
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t4_busy",  a_busy,  1'b0);
    chk("t4_done",  a_done,  1'b0);
    chk("t4_sum",   a_sum,   8'h00);
    chk("t4_carry", a_carry, 1'b0);
    clear_stats();
    for (int c = 0; c < 10; c++) begin
      sample(c, a_busy, a_done, a_sum, a_carry);
      tick();
    end
    chk("t4_no_done", done_cnt, 0);
    chk("t4_no_busy", busy_cnt, 0);

    // back-to-back with start held high
    clear_stats();
    a_x = 8'h01; a_y = 8'h01; a_cin = 0; a_start = 1;
    tick();
    a_x = 8'h80; a_y = 8'h80;
    for (int c = 0; c < 22; c++) begin
      sample(c, a_busy, a_done, a_sum, a_carry);
      if (first_done >= 0 && c > first_done && !a_done && second_done < 0 && a_sum !== 8'h02)
        unstable++;
      if (c == 10) a_start = 0;
      tick();
    end
    chk("t5_done_count",  done_cnt,                 2);
    chk("t5_first_lat",   first_done,               8);
    chk("t5_spacing",     second_done - first_done, 9);
    chk("t5_first_sum",   first_sum,                8'h02);
    chk("t5_first_carry", first_carry,              1'b0);
    chk("t5_second_sum",  done_sum,                 8'h00);
    chk("t5_second_carry", done_carry,              1'b1);
    chk("t5_sum_stable",  unstable,                 0);
    chk("t5_overlap",     overlap,                  0);
    chk("t5_busy",        busy_cnt,                 16);

    // randomised sweep, WIDTH=16, every CHUNK in parallel
    for (int op = 0; op < 1000; op++) begin
      w_x   = 16'($urandom);
      w_y   = 16'($urandom);
      w_cin = 1'($urandom_range(0, 1));
      if (op == 0) begin w_x = 16'hFFFF; w_y = 16'hFFFF; w_cin = 1; end
      if (op == 1) begin w_x = 16'hFFFF; w_y = 16'h0000; w_cin = 1; end
      expv = {1'b0, w_x} + {1'b0, w_y} + {16'h0000, w_cin};
      for (int i = 0; i < 5; i++) begin
        lat[i] = 0; dcnt[i] = 0; res[i] = '0;
      end
      w_start = 1;
      tick();
      w_start = 0;
      w_x = '0; w_y = '0; w_cin = 0;
      for (int c = 1; c <= 18; c++) begin
        tick();
        for (int i = 0; i < 5; i++) begin
          if (w_done[i]) begin
            dcnt[i]++;
            if (lat[i] == 0) begin
              lat[i] = c;
              res[i] = {w_carry[i], w_sum[i]};
            end
          end
        end
      end
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("sweep_c%0d_latency", 1 << i), lat[i],  16 >> i);
        chk($sformatf("sweep_c%0d_dones", 1 << i),   dcnt[i], 1);
        chk($sformatf("sweep_c%0d_result", 1 << i),  res[i],  expv);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
